// File: rtl/bless_traffic_gen.sv
// Flit source/sink for one BLESS router local port: emits header+data packets with a
// saturating wait age on the header, and checks ejected packets against the same payload rule.
module bless_traffic_gen #(
  parameter int              CW      = 28,
  parameter int              DW      = 128,
  parameter int              DEST_W  = 4,
  parameter int              AGE_W   = 8,
  parameter int              MY_ID   = 0,
  parameter logic [DW-1:0]   PATTERN = 128'h0123456789abcdef0123456789abcdef
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [15:0]       num_pkts,
  input  logic [DEST_W-1:0] dest,
  input  logic [7:0]        gap,
  input  logic              mode,
  input  logic              inj_ready,
  output logic [CW-1:0]     inj_co,
  output logic [DW-1:0]     inj_do,
  input  logic [CW-1:0]     ej_ci,
  input  logic [DW-1:0]     ej_di,
  output logic              busy,
  output logic              done,
  output logic [15:0]       sent_cnt,
  output logic [15:0]       recv_cnt,
  output logic              err
);

  localparam int SEQ_W = CW - 1 - AGE_W - DEST_W;

  typedef enum logic [2:0] {S_IDLE, S_HEAD, S_DATA, S_GAP, S_DONE} state_t;

  function automatic logic [DW-1:0] f_payload(input logic [SEQ_W-1:0] seq, input logic m);
    logic [DW-1:0] w_rep;
    w_rep = '0;
    for (int i = 0; i < DW / 16; i++) w_rep[i*16 +: 16] = 16'(seq);
    return m ? PATTERN : w_rep;
  endfunction

  state_t            r_state, w_state_nx;
  logic [15:0]       r_left, w_left_nx;
  logic [DEST_W-1:0] r_dest, w_dest_nx;
  logic [7:0]        r_gap, w_gap_nx;
  logic [7:0]        r_gap_cnt, w_gap_cnt_nx;
  logic              r_mode, w_mode_nx;
  logic [AGE_W-1:0]  r_age, w_age_nx;
  logic [15:0]       r_sent, w_sent_nx;
  logic [CW-1:0]     r_inj_co, w_co_nx;
  logic [DW-1:0]     r_inj_do, w_do_nx;
  logic              r_busy, r_done, w_done_nx;

  logic              r_chk_pend;
  logic [SEQ_W-1:0]  r_chk_seq;
  logic [15:0]       r_recv;
  logic              r_err;

  // Every output is computed for the state being entered, so the registers show it
  // in the same cycle the FSM is in that state.
  always_comb begin
    // NOTE: every variable gets a default before the case so no path infers a latch.
    w_state_nx   = r_state;
    w_left_nx    = r_left;
    w_dest_nx    = r_dest;
    w_gap_nx     = r_gap;
    w_gap_cnt_nx = r_gap_cnt;
    w_mode_nx    = r_mode;
    w_age_nx     = r_age;
    w_sent_nx    = r_sent;
    w_co_nx      = '0;
    w_do_nx      = '0;
    w_done_nx    = 1'b0;
    case (r_state)
      S_IDLE: if (start) begin
        w_left_nx = num_pkts;
        w_dest_nx = dest;
        w_gap_nx  = gap;
        w_mode_nx = mode;
        w_age_nx  = '0;
        if (num_pkts != 16'd0) w_state_nx = S_HEAD;
        else                   w_done_nx  = 1'b1;
      end
      S_HEAD: if (inj_ready) begin
        w_sent_nx  = r_sent + 16'd1;
        w_left_nx  = r_left - 16'd1;
        w_do_nx    = f_payload(r_sent[SEQ_W-1:0], r_mode);
        w_state_nx = S_DATA;
      end else if (r_age != '1) begin
        w_age_nx = r_age + 1'b1;
      end
      S_DATA: begin
        w_age_nx = '0;
        if (r_left == 16'd0) begin
          w_state_nx = S_DONE;
          w_done_nx  = 1'b1;
        end else if (r_gap != 8'd0) begin
          w_state_nx   = S_GAP;
          w_gap_cnt_nx = r_gap - 8'd1;
        end else begin
          w_state_nx = S_HEAD;
        end
      end
      S_GAP: begin
        if (r_gap_cnt == 8'd0) w_state_nx   = S_HEAD;
        else                   w_gap_cnt_nx = r_gap_cnt - 8'd1;
      end
      S_DONE:  w_state_nx = S_IDLE;
      default: w_state_nx = S_IDLE;
    endcase
    // r_sent already reflects the previous acceptance when a new header is presented.
    if (w_state_nx == S_HEAD) w_co_nx = {1'b1, w_age_nx, r_sent[SEQ_W-1:0], w_dest_nx};
  end

  always_ff @(posedge clk) begin
    // NOTE: the sync reset clears every register, run parameters included, so a
    // mid-run reset leaves no stale configuration behind.
    if (rst) begin
      r_state   <= S_IDLE;
      r_left    <= '0;
      r_dest    <= '0;
      r_gap     <= '0;
      r_gap_cnt <= '0;
      r_mode    <= 1'b0;
      r_age     <= '0;
      r_sent    <= '0;
      r_inj_co  <= '0;
      r_inj_do  <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so all registers update from pre-edge values.
      r_state   <= w_state_nx;
      r_left    <= w_left_nx;
      r_dest    <= w_dest_nx;
      r_gap     <= w_gap_nx;
      r_gap_cnt <= w_gap_cnt_nx;
      r_mode    <= w_mode_nx;
      r_age     <= w_age_nx;
      r_sent    <= w_sent_nx;
      r_inj_co  <= w_co_nx;
      r_inj_do  <= w_do_nx;
      r_busy    <= (w_state_nx != S_IDLE);
      r_done    <= w_done_nx;
    end
  end

  // Ejection checker: header latched on one edge, its data word compared on the next.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_chk_pend <= 1'b0;
      r_chk_seq  <= '0;
      r_recv     <= '0;
      r_err      <= 1'b0;
    end else begin
      if (r_chk_pend) begin
        r_recv <= r_recv + 16'd1;
        if (ej_di != f_payload(r_chk_seq, r_mode)) r_err <= 1'b1;
      end
      r_chk_pend <= ej_ci[CW-1];
      if (ej_ci[CW-1]) begin
        r_chk_seq <= ej_ci[DEST_W +: SEQ_W];
        if (ej_ci[DEST_W-1:0] != DEST_W'(MY_ID)) r_err <= 1'b1;
      end
    end
  end

  logic w_unused_age;
  assign w_unused_age = ^ej_ci[CW-2 -: AGE_W];

  assign inj_co   = r_inj_co;
  assign inj_do   = r_inj_do;
  assign busy     = r_busy;
  assign done     = r_done;
  assign sent_cnt = r_sent;
  assign recv_cnt = r_recv;
  assign err      = r_err;

endmodule

// File: tb/tb_bless_traffic_gen.sv
// Bench for bless_traffic_gen: a procedural per-packet timeline predicts every output cycle,
// with optional gated loopback into the checker, random readiness, start noise and corruption.
module tb_bless_traffic_gen;

  localparam logic [127:0] PAT = 128'h0123456789abcdef0123456789abcdef;

  logic         clk = 1'b0;
  logic         rst, start, mode, inj_ready;
  logic [15:0]  num_pkts;
  logic [3:0]   dest;
  logic [7:0]   gap;
  logic [27:0]  inj_co, ej_ci;
  logic [127:0] inj_do, ej_di;
  logic         busy, done, err;
  logic [15:0]  sent_cnt, recv_cnt;

  always #5 clk = ~clk;

  bless_traffic_gen dut (
    .clk(clk), .rst(rst), .start(start), .num_pkts(num_pkts), .dest(dest), .gap(gap),
    .mode(mode), .inj_ready(inj_ready), .inj_co(inj_co), .inj_do(inj_do),
    .ej_ci(ej_ci), .ej_di(ej_di), .busy(busy), .done(done), .sent_cnt(sent_cnt),
    .recv_cnt(recv_cnt), .err(err)
  );

  // Loopback models a router that ejects exactly the headers it accepted.
  logic         lb_en = 1'b0;
  logic [3:0]   dest_flip = '0;
  logic [127:0] data_flip = '0;
  assign ej_ci = (lb_en && inj_ready && inj_co[27]) ? (inj_co ^ {24'd0, dest_flip}) : '0;
  assign ej_di = lb_en ? (inj_do ^ data_flip) : '0;

  int n_checks = 0;
  int n_errs   = 0;

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // Expected state of the world for the current cycle.
  logic [27:0]  exp_co;
  logic [127:0] exp_do;
  logic         exp_busy, exp_done, exp_err;
  logic [15:0]  exp_sent, exp_recv;
  bit           cmp_en = 0;
  bit           chk_latch, chk_latch_bad, chk_latch_dest_bad, chk_due, chk_due_bad;

  int           cyc = 0, acc_cyc = 0, prev_acc_cyc = 0, hdr_cnt = 0, done_cnt = 0;
  logic [27:0]  acc_hdr = '0;
  logic [127:0] last_do = '0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) if (cmp_en) begin
    check("inj_co",   inj_co,   exp_co);
    check("inj_do",   inj_do,   exp_do);
    check("busy",     busy,     exp_busy);
    check("done",     done,     exp_done);
    check("sent_cnt", sent_cnt, exp_sent);
    check("recv_cnt", recv_cnt, exp_recv);
    check("err",      err,      exp_err);
    if (inj_ready && inj_co[27]) begin
      prev_acc_cyc = acc_cyc;
      acc_cyc      = cyc;
      acc_hdr      = inj_co;
    end
    if (inj_co[27]) hdr_cnt++;
    if (inj_do != '0) last_do = inj_do;
    if (done) done_cnt++;
  end

  function automatic logic [27:0] hdr(input int age, input logic [14:0] seq, input logic [3:0] d);
    return {1'b1, 8'(age), seq, d};
  endfunction

  function automatic logic [127:0] payload(input logic [14:0] seq, input bit m);
    return m ? PAT : {8{{1'b0, seq}}};
  endfunction

  task automatic set_exp(input logic [27:0] co, input logic [127:0] dw, input logic b, input logic dn);
    exp_co = co; exp_do = dw; exp_busy = b; exp_done = dn;
  endtask

  task automatic reset_model();
    set_exp('0, '0, 1'b0, 1'b0);
    exp_sent = '0; exp_recv = '0; exp_err = 1'b0;
    chk_latch = 0; chk_latch_bad = 0; chk_latch_dest_bad = 0; chk_due = 0; chk_due_bad = 0;
  endtask

  // Advance one clock; the checker's latch/compare pipeline advances with it.
  task automatic step();
    @(posedge clk); #1;
    if (chk_due) begin
      exp_recv++;
      if (chk_due_bad) exp_err = 1'b1;
    end
    if (chk_latch && chk_latch_dest_bad) exp_err = 1'b1;
    chk_due     = chk_latch;
    chk_due_bad = chk_latch_bad;
    chk_latch   = 0;
  endtask

  task automatic do_reset();
    rst = 1'b1; start = 1'b0;
    step();
    reset_model();
    rst = 1'b0;
  endtask

  bit noise_en = 0;
  task automatic noise();
    if (noise_en && $urandom_range(0, 5) == 0) begin
      start = 1'b1; num_pkts = 16'($urandom); dest = 4'($urandom);
      gap = 8'($urandom); mode = 1'($urandom);
    end else start = 1'b0;
  endtask

  task automatic run(input int n, input logic [3:0] d, input int g, input bit m, input int hold,
                     input int pct, input int abort_at, input int bad_data, input int bad_dest);
    int age, waited;
    bit rdy;
    logic [14:0] seq;
    num_pkts = 16'(n); dest = d; gap = 8'(g); mode = m; start = 1'b1;
    step();
    start = 1'b0;
    if (n == 0) begin
      set_exp('0, '0, 1'b0, 1'b1);
      step();
      set_exp('0, '0, 1'b0, 1'b0);
      return;
    end
    for (int p = 0; p < n; p++) begin
      age = 0; waited = 0;
      forever begin
        set_exp(hdr(age, exp_sent[14:0], d), '0, 1'b1, 1'b0);
        noise();
        rdy = (waited >= hold) && ((waited >= hold + 20) || ($urandom_range(0, 99) < pct));
        inj_ready = rdy;
        if (rdy && lb_en) begin
          chk_latch          = 1;
          chk_latch_bad      = (p == bad_data);
          chk_latch_dest_bad = (d != 4'd0) || (p == bad_dest);
          dest_flip          = (p == bad_dest) ? 4'h1 : 4'h0;
        end
        step();
        dest_flip = '0;
        if (rdy) break;
        waited++;
        age = (age == 255) ? 255 : age + 1;
      end
      seq = exp_sent[14:0];
      exp_sent++;
      set_exp('0, payload(seq, m), 1'b1, 1'b0);
      noise();
      inj_ready = 1'($urandom);
      data_flip = (p == bad_data) ? (128'd1 << $urandom_range(0, 127)) : '0;
      if (p == abort_at) begin
        rst = 1'b1;
        step();
        reset_model();
        rst = 1'b0; data_flip = '0; start = 1'b0;
        return;
      end
      step();
      data_flip = '0;
      if (p < n - 1) repeat (g) begin
        set_exp('0, '0, 1'b1, 1'b0);
        noise();
        step();
      end
    end
    set_exp('0, '0, 1'b1, 1'b1);
    noise();
    step();
    start = 1'b0;
    set_exp('0, '0, 1'b0, 1'b0);
  endtask

  int dc, hc;

  initial begin
    rst = 1'b1; start = 1'b0; num_pkts = '0; dest = '0; gap = '0; mode = 1'b0; inj_ready = 1'b0;
    reset_model();
    repeat (3) @(posedge clk);
    #1;
    cmp_en = 1;
    rst = 1'b0;
    step();
    check("reset_co", inj_co, 28'h0);
    check("reset_busy", busy, 1'b0);

    // Single PATTERN packet, immediate acceptance.
    run(1, 4'd1, 0, 1'b1, 0, 100, -1, -1, -1);
    check("t1_hdr", acc_hdr, 28'h8000001);
    check("t1_data", last_do, PAT);
    check("t1_sent", sent_cnt, 16'd1);
    check("t1_done", done_cnt, 1);

    // Five stalled cycles, accepted with age 5 and seq 1.
    run(1, 4'd0, 0, 1'b0, 5, 100, -1, -1, -1);
    check("t2_hdr", acc_hdr, 28'h8280010);
    check("t2_data", last_do, {8{16'h0001}});

    // Three packets, gap 2: headers four cycles apart.
    do_reset();
    run(3, 4'd0, 2, 1'b0, 0, 100, -1, -1, -1);
    check("t3_period", acc_cyc - prev_acc_cyc, 4);
    check("t3_hdr", acc_hdr, 28'h8000020);
    check("t3_data", last_do, {8{16'h0002}});

    // Age saturation over a 300-cycle stall.
    run(1, 4'd0, 0, 1'b0, 300, 100, -1, -1, -1);
    check("t4_age", acc_hdr[26:19], 8'hff);

    // Empty run: done pulse, no header.
    dc = done_cnt; hc = hdr_cnt;
    run(0, 4'd0, 0, 1'b0, 0, 100, -1, -1, -1);
    check("t5_done", done_cnt - dc, 1);
    check("t5_nohdr", hdr_cnt - hc, 0);

    // Randomised loopback runs with start noise.
    do_reset();
    lb_en = 1'b1; noise_en = 1;
    repeat (25) run($urandom_range(1, 5), 4'd0, $urandom_range(0, 3), 1'($urandom),
                    $urandom_range(0, 3), 60, -1, -1, -1);
    check("lb_recv", recv_cnt, exp_sent);
    check("lb_err", err, 1'b0);

    // Random destinations without ejection traffic.
    lb_en = 1'b0;
    repeat (10) run($urandom_range(0, 4), 4'($urandom), $urandom_range(0, 3), 1'($urandom),
                    $urandom_range(0, 2), 70, -1, -1, -1);
    check("nolb_err", err, 1'b0);

    // Corrupted data bit: err sets and sticks.
    lb_en = 1'b1;
    run(3, 4'd0, 1, 1'($urandom), 0, 80, -1, 1, -1);
    check("bad_data_err", err, 1'b1);
    run(2, 4'd0, 0, 1'b0, 0, 100, -1, -1, -1);
    check("err_sticky", err, 1'b1);

    // Reset during DATA, then a normal run.
    noise_en = 0;
    run(3, 4'd0, 0, 1'b0, 0, 100, 1, -1, -1);
    check("abort_co", inj_co, 28'h0);
    check("abort_busy", busy, 1'b0);
    check("abort_sent", sent_cnt, 16'd0);
    check("abort_err", err, 1'b0);
    run(2, 4'd0, 1, 1'b1, 0, 100, -1, -1, -1);
    check("post_abort_sent", sent_cnt, 16'd2);
    check("post_abort_recv", recv_cnt, 16'd2);

    // Wrong destination on ejection.
    run(2, 4'd0, 0, 1'b0, 0, 100, -1, -1, 0);
    check("bad_dest_err", err, 1'b1);
    do_reset();
    run(1, 4'd3, 0, 1'b0, 0, 100, -1, -1, -1);
    check("not_my_id_err", err, 1'b1);

    step();
    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule

// File: doc/bless_traffic_gen.md
# bless_traffic_gen

Parametrised, synthesizable flit source and sink for one bufferless (BLESS, age-arbitrated) router injection/ejection port pair. It generates packets as a header control word followed one cycle later by a data word, and holds each header until the router signals injection readiness. It stamps headers with a saturating wait age and checks returned flits against the same payload rule. It sits between a node/test harness and the router's local port, replacing hand-written stimulus for power and throughput characterisation.

## Interface
- CW, 28, control word width; requires CW >= AGE_W+DEST_W+2
- DW, 128, data word width; multiple of 16
- DEST_W, 4, destination/node-ID field width
- AGE_W, 8, age field width
- MY_ID, 0, this node's ID; ejected headers must carry it
- PATTERN, 128'h0123456789abcdef0123456789abcdef, mode-1 payload (DW bits)
- clk  in  1  clock, rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  one-cycle request to begin a run; ignored while busy
- num_pkts  in  16  packets in run, sampled on accepted start
- dest  in  DEST_W  destination, sampled on accepted start
- gap  in  8  idle cycles between packets, sampled on accepted start
- mode  in  1  0 = sequence payload, 1 = PATTERN payload; sampled on start
- inj_ready  in  1  router can accept a header this cycle
- inj_co  out  CW  injected control word
- inj_do  out  DW  injected data word
- ej_ci  in  CW  ejected control word
- ej_di  in  DW  ejected data word, one cycle after its header
- busy  out  1  run in progress
- done  out  1  one-cycle pulse at run end
- sent_cnt  out  16  headers accepted since reset
- recv_cnt  out  16  packets checked since reset
- err  out  1  sticky check failure

## Operation
- Header layout, MSB first: valid [CW-1], age [AGE_W], seq [SEQ_W = CW-1-AGE_W-DEST_W], dest [DEST_W-1:0]. CW=28 defaults: valid 27, age 26:19, seq 18:4, dest 3:0.
- seq is sent_cnt[SEQ_W-1:0] at presentation; wraps modulo 2^SEQ_W.
- Payload, mode 0: seq zero-extended to 16 bits, replicated DW/16 times. Mode 1: PATTERN.
- FSM states and transitions:
  - IDLE: on start, go to HEAD if num_pkts != 0. If num_pkts == 0, pulse done and stay IDLE.
  - HEAD: drive header, valid=1. Age starts at 0 and increments each cycle that inj_ready=0, saturating at all-ones. On inj_ready=1, the header is accepted, sent_cnt increments (wraps at 2^16), and the FSM goes to DATA.
  - DATA: inj_co=0 and inj_do=payload for exactly one cycle, regardless of inj_ready. If packets remain, go to GAP when gap != 0, else directly to HEAD. If none remain, go to DONE.
  - GAP: all outputs zero for gap cycles, then HEAD.
  - DONE: pulse done for one cycle, then IDLE.
- busy=1 in every state except IDLE.
- Checker, independent of the FSM:
  - ej_ci[CW-1]=1 latches seq and dest.
  - If dest != MY_ID, set err.
  - Next cycle, compare ej_di with the expected payload for the latched seq under the current mode. A mismatch sets err. recv_cnt increments (wraps) either way.
  - A new header in the compare cycle is accepted (back-to-back packets).
- err clears only on rst.

## Timing
- All outputs are registered.
- Reset values: inj_co=0, inj_do=0, busy=0, done=0, sent_cnt=0, recv_cnt=0, err=0; FSM in IDLE; age 0.
- Accepted start at edge t gives a header on inj_co from t+1.
- Header sampled with inj_ready=1 at edge k gives data on inj_do during cycle k..k+1, then inj_do=0.
- Minimum packet period is 2 cycles (gap=0, inj_ready held high).
- done rises one cycle after the last DATA cycle; busy falls with done.
- start during busy is ignored; run parameters do not change mid-run.
- rst mid-run: all of the above reset values at the next edge. Any in-flight data word is abandoned, and the checker pipeline is flushed.
- Age saturates and does not wrap, e.g. 255 stays 255 for AGE_W=8.

## Test plan
- Reset, then start with num_pkts=1, dest=1, mode=1, inj_ready=1. Expect inj_co=28'h8000001 for one cycle, then inj_do=PATTERN, then done pulse; sent_cnt=1.
- inj_ready held 0 for 5 cycles in HEAD. Expect the header held with age 0,1,2,3,4, accepted with age 5; data follows the next cycle.
- num_pkts=3, gap=2, mode=0, inj_ready=1. Expect headers 4 cycles apart with seq 0,1,2; data words 16'h0000.., 16'h0001.., 16'h0002.. replicated.
- Loop inj_co/inj_do back to ej_ci/ej_di with MY_ID=dest. Expect recv_cnt=sent_cnt and err=0. Corrupt one data bit and expect err=1 and sticky; a wrong dest also sets err.
- Hold inj_ready=0 for 300 cycles. Expect age=8'hff sustained.
- Assert rst during DATA. Expect all outputs zero next edge; a later start works normally.
- num_pkts=0. Expect a done pulse next cycle with no valid header.
